uart_tx_fifo: RTL and testbench

- UART transmitter for the core's outbound serial path. It is the counterpart of the board's UART_RX receive path.
- Accepts bytes from the core through a write strobe into an internal FIFO.
- Serialises each byte onto UART_TX as 8N1: start bit, 8 data bits LSB first, stop bit.
- Sits between the core's output-instruction path and the board TX pin, and shares the bit period used by the receive side.

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: core-side write port and status of the UART transmitter.
// Latency: none, wires only.
// Backpressure: full and overflow report back to the writer; the writer owns wr_en/data_in.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH_LOG = 4
);
  logic                      wr_en;
  logic [7:0]                data_in;
  logic                      full;
  logic [FIFO_DEPTH_LOG:0]   fifo_count;
  logic                      busy;
  logic                      overflow;

  // core side: pushes bytes and watches status
  modport master (
    output wr_en, data_in,
    input  full, fifo_count, busy, overflow
  );

  // transmitter side
  modport slave (
    input  wr_en, data_in,
    output full, fifo_count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serialiser on UART_TX; UART_TX_PARITY_EN adds an even parity bit.
// Latency: UART_TX falls one cycle after a write into an empty idle block; a frame is 10 (11 with parity) bit periods.
// Backpressure: full is registered; writes while full are dropped and set the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT    = 271,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  uart_tx_fifo_if.slave bus,
  output logic          UART_TX
);

  localparam int                      DEPTH     = 1 << FIFO_DEPTH_LOG;
  localparam logic [15:0]             BAUD_LAST = 16'(CLK_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG:0] FULL_CNT  = {1'b1, {FIFO_DEPTH_LOG{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG:0] PTR_ONE   = {{FIFO_DEPTH_LOG{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG:0]   wr_ptr;
  logic [FIFO_DEPTH_LOG:0]   rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;
  logic [FIFO_DEPTH_LOG:0]   count_nxt;
  logic [7:0]                head;
  logic                      full_q;
  logic                      ovf_q;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      bit_done;

  logic [2:0]                state;
  logic [15:0]               baud;
  logic [2:0]                bit_idx;
  logic [7:0]                shift;
  logic                      tx_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity;
`endif

  // Pointers are one bit wider than the address, so their difference is the occupancy
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr[FIFO_DEPTH_LOG-1:0]];
  assign push      = bus.wr_en & ~full_q;
  assign bit_done  = (baud == BAUD_LAST);
  // Pop from IDLE, or at the end of a stop bit so frames run back to back
  assign pop       = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
  assign count_nxt = count + {{FIFO_DEPTH_LOG{1'b0}}, push} - {{FIFO_DEPTH_LOG{1'b0}}, pop};

  assign bus.full       = full_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != S_IDLE) | ~empty;
  assign UART_TX        = tx_q;

  // FIFO storage, written on accepted pushes only
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[FIFO_DEPTH_LOG-1:0]] <= bus.data_in;
    end
  end

  // FIFO pointers, registered full flag and sticky overflow
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      full_q <= (count_nxt == FULL_CNT);
      if (bus.wr_en && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Frame FSM; the line value for the next bit is registered on each transition
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud <= '0;
          if (pop) begin
            shift  <= head;
`ifdef UART_TX_PARITY_EN
            parity <= ^head;
`endif
            state  <= S_START;
            tx_q   <= 1'b0;
          end else begin
            tx_q   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx_q    <= shift[0];
          end else begin
            baud    <= baud + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud    <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= parity;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              tx_q  <= shift[1];
            end
          end else begin
            baud    <= baud + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            baud  <= '0;
            state <= S_STOP;
            tx_q  <= 1'b1;
          end else begin
            baud  <= baud + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            baud <= '0;
            if (pop) begin
              shift  <= head;
`ifdef UART_TX_PARITY_EN
              parity <= ^head;
`endif
              state  <= S_START;
              tx_q   <= 1'b0;
            end else begin
              state  <= S_IDLE;
              tx_q   <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          baud  <= '0;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks uart_tx_fifo against a frame-timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int S_CPB   = 271;
  localparam int S_LOG   = 4;
  localparam int F_CPB   = 4;
  localparam int F_LOG   = 2;
  localparam int F_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int S_FRAME = NB * S_CPB;
  localparam int F_FRAME = NB * F_CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_s;
  logic tx_f;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH_LOG(S_LOG)) if_s ();
  uart_tx_fifo_if #(.FIFO_DEPTH_LOG(F_LOG)) if_f ();

  uart_tx_fifo #(.CLK_PER_BIT(S_CPB), .FIFO_DEPTH_LOG(S_LOG)) u_slow (
    .CLK(clk), .RST_N(rst_n), .bus(if_s), .UART_TX(tx_s)
  );
  uart_tx_fifo #(.CLK_PER_BIT(F_CPB), .FIFO_DEPTH_LOG(F_LOG)) u_fast (
    .CLK(clk), .RST_N(rst_n), .bus(if_f), .UART_TX(tx_f)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of bit period k of a frame carrying byte d
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0)      return 1'b0;
    if (k <= 8)      return d[k-1];
    if (k == NB - 1) return 1'b1;
    return ^d;
  endfunction

  // Reference model: queue of waiting bytes plus the edge at which the current frame ends
  logic [7:0]  q [$];
  longint      n = 0;
  longint      end_edge = 0;
  logic [7:0]  cur = 8'h00;
  logic        ovf_m = 1'b0;

  // Frame decoder on the fast line: samples mid-bit after each falling start edge
  int          dec_off = -1;
  logic        dec_prev = 1'b1;
  logic [10:0] dec_f = '0;
  logic [10:0] fq [$];

  function automatic logic model_line();
    int k;
    if (n >= end_edge) return 1'b1;
    k = int'(n - (end_edge - F_FRAME)) / F_CPB;
    return frame_bit(cur, k);
  endfunction

  task automatic mreset();
    q.delete();
    end_edge = n;
    ovf_m    = 1'b0;
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d);
    int pre;
    if_f.wr_en   = wr;
    if_f.data_in = d;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      mreset();
    end else begin
      pre = q.size();
      if (wr && pre == F_DEPTH) ovf_m = 1'b1;
      if (pre > 0 && n >= end_edge) begin
        cur      = q.pop_front();
        end_edge = n + F_FRAME;
      end
      if (wr && pre < F_DEPTH) q.push_back(d);
    end
    #1;
    chk("line",     tx_f,            model_line());
    chk("busy",     if_f.busy,       (n < end_edge) || (q.size() > 0));
    chk("full",     if_f.full,       q.size() == F_DEPTH);
    chk("count",    if_f.fifo_count, q.size());
    chk("overflow", if_f.overflow,   ovf_m);
    if (!rst_n) begin
      dec_off = -1;
    end else if (dec_off < 0) begin
      if (dec_prev && !tx_f) begin
        dec_off = 0;
        dec_f   = '0;
      end
    end else begin
      dec_off++;
    end
    if (dec_off >= 0 && (dec_off % F_CPB) == F_CPB / 2) dec_f[dec_off / F_CPB] = tx_f;
    if (dec_off == F_FRAME - 1) begin
      fq.push_back(dec_f);
      dec_off = -1;
    end
    dec_prev = tx_f;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      cycle(1'b0, 8'h00);
      if (!if_f.busy && dec_off < 0) break;
    end
    chk("drain_idle", if_f.busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [9:0] frame;   // {stop, d7..d0, start}
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          bc;
    logic [10:0] exp_f;

    tbl[0] = '{8'hA5, 1'b0, 10'b1_10100101_0};
    tbl[1] = '{8'h00, 1'b0, 10'b1_00000000_0};
    tbl[2] = '{8'hFF, 1'b0, 10'b1_11111111_0};
    tbl[3] = '{8'h3C, 1'b0, 10'b1_00111100_0};
    tbl[4] = '{8'h07, 1'b1, 10'b1_00000111_0};
    tbl[5] = '{8'h80, 1'b1, 10'b1_10000000_0};
    tbl[6] = '{8'h01, 1'b1, 10'b1_00000001_0};

    if_s.wr_en = 1'b0; if_s.data_in = 8'h00;
    if_f.wr_en = 1'b0; if_f.data_in = 8'h00;

    // Reset and idle on the 271-cycle instance
    repeat (5) @(posedge clk);
    #1;
    chk("rst_line",  tx_s,            1'b1);
    chk("rst_busy",  if_s.busy,       1'b0);
    chk("rst_full",  if_s.full,       1'b0);
    chk("rst_count", if_s.fifo_count, 0);
    chk("rst_ovf",   if_s.overflow,   1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      chk("idle_line",  tx_s,            1'b1);
      chk("idle_busy",  if_s.busy,       1'b0);
      chk("idle_full",  if_s.full,       1'b0);
      chk("idle_count", if_s.fifo_count, 0);
    end

    // Single byte A5: line stays high on the write edge, falls on the pop edge
    if_s.wr_en = 1'b1; if_s.data_in = 8'hA5;
    @(posedge clk); #1;
    if_s.wr_en = 1'b0;
    chk("a5_wr_line",  tx_s,            1'b1);
    chk("a5_wr_count", if_s.fifo_count, 1);
    @(posedge clk); #1;
    chk("a5_pop_count", if_s.fifo_count, 0);
    for (int j = 0; j < S_FRAME; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      chk("a5_line", tx_s,      frame_bit(8'hA5, j / S_CPB));
      chk("a5_busy", if_s.busy, 1'b1);
    end
    @(posedge clk); #1;
    chk("a5_done_busy", if_s.busy, 1'b0);
    chk("a5_done_line", tx_s,      1'b1);

    // Fast instance: reset with the model in step
    rst_n = 1'b0;
    repeat (3) cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, 8'h00);

    // Back-to-back frames: busy counted from the first pop edge
    bc = 0;
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF); if (if_f.busy) bc++;
    cycle(1'b1, 8'h3C); if (if_f.busy) bc++;
    for (int c = 0; c < 400; c++) begin
      cycle(1'b0, 8'h00);
      if (!if_f.busy) break;
      bc++;
    end
    chk("b2b_busy_cycles", bc, 3 * F_FRAME);

    // Full and overflow with a 4-deep FIFO
    drain(100);
    fq.delete();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 8'(i));
      if (i == 5) begin
        chk("full_set",   if_f.full,       1'b1);
        chk("full_count", if_f.fifo_count, 4);
        chk("ovf_clear",  if_f.overflow,   1'b0);
      end
    end
    chk("ovf_set",     if_f.overflow,   1'b1);
    chk("ovf_count",   if_f.fifo_count, 4);
    drain(400);
    chk("ovf_nframes", fq.size(), 5);
    for (int i = 0; i < fq.size() && i < 5; i++) chk("ovf_order", fq[i][8:1], i + 1);

    // Table of single frames
    for (int t = 0; t < 7; t++) begin
      drain(100);
      fq.delete();
      cycle(1'b1, tbl[t].data);
      drain(100);
`ifdef UART_TX_PARITY_EN
      exp_f = {1'b1, tbl[t].par, tbl[t].frame[8:0]};
`else
      exp_f = {1'b0, tbl[t].frame};
`endif
      chk("tbl_nframes", fq.size(), 1);
      if (fq.size() > 0) chk("tbl_frame", fq[0], exp_f);
    end

    // Random traffic: a dense phase that overflows, then a sparse phase
    for (int c = 0; c < 500; c++) cycle($urandom_range(0, 99) < 30, 8'($urandom));
    for (int c = 0; c < 800; c++) cycle($urandom_range(0, 99) < 3,  8'($urandom));
    drain(400);

    // Reset during data bit 3 of the first of two frames
    fq.delete();
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'hAA);
    repeat (17) cycle(1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line",  tx_f,            1'b1);
    chk("mid_rst_count", if_f.fifo_count, 0);
    chk("mid_rst_busy",  if_f.busy,       1'b0);
    chk("mid_rst_full",  if_f.full,       1'b0);
    chk("mid_rst_ovf",   if_f.overflow,   1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (200) cycle(1'b0, 8'h00);
    chk("mid_rst_nframes", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
